// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences ALU, shared memory
// port and register file for lw/sw/R/I/beq/jal.
module multicycle_ctrl #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [6:0]         op,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               adr_src,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         result_src,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic               reg_write,
  output logic [1:0]         alu_op,
  output logic               instr_done,
  output logic               illegal_instr,
  output logic [STATE_W-1:0] dbg_state
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;

  localparam logic [1:0] SrcPc    = 2'b00;
  localparam logic [1:0] SrcOldPc = 2'b01;
  localparam logic [1:0] SrcRd1   = 2'b10;
  localparam logic [1:0] SrcRd2   = 2'b00;
  localparam logic [1:0] SrcImm   = 2'b01;
  localparam logic [1:0] SrcFour  = 2'b10;

  localparam logic [1:0] ResAluOut  = 2'b00;
  localparam logic [1:0] ResData    = 2'b01;
  localparam logic [1:0] ResAluRes  = 2'b10;

  localparam logic [1:0] AluAdd   = 2'b00;
  localparam logic [1:0] AluSub   = 2'b01;
  localparam logic [1:0] AluFunct = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    Fetch    = STATE_W'(0),
    Decode   = STATE_W'(1),
    MemAdr   = STATE_W'(2),
    MemRead  = STATE_W'(3),
    MemWb    = STATE_W'(4),
    MemWrite = STATE_W'(5),
    ExecR    = STATE_W'(6),
    ExecI    = STATE_W'(7),
    AluWb    = STATE_W'(8),
    Beq      = STATE_W'(9),
    Jal      = STATE_W'(10),
    Trap     = STATE_W'(11)
  } stateE;

  stateE state;
  stateE nextState;

  logic isLoad;
  logic isStore;
  logic isRType;
  logic isIType;
  logic isBeq;
  logic isJal;

  assign isLoad  = (op == OpLoad);
  assign isStore = (op == OpStore);
  assign isRType = (op == OpRType);
  assign isIType = (op == OpIType);
  assign isBeq   = (op == OpBeq);
  assign isJal   = (op == OpJal);

  assign dbg_state = state;

  // State register; reset lands in Fetch from any state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= Fetch;
    end else begin
      state <= nextState;
    end
  end

  // Sticky illegal flag, raised as the FSM enters Trap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      illegal_instr <= 1'b0;
    end else if (nextState == Trap) begin
      illegal_instr <= 1'b1;
    end
  end

  // Immediate format follows the opcode directly.
  always_comb begin
    imm_src = 2'b00;
    unique case (1'b1)
      isStore: imm_src = 2'b01;
      isBeq:   imm_src = 2'b10;
      isJal:   imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  // Opcode dispatch out of Decode.
  stateE decodeNext;
  always_comb begin
    decodeNext = Trap;
    unique case (1'b1)
      isLoad:  decodeNext = MemAdr;
      isStore: decodeNext = MemAdr;
      isRType: decodeNext = ExecR;
      isIType: decodeNext = ExecI;
      isBeq:   decodeNext = Beq;
      isJal:   decodeNext = Jal;
      default: decodeNext = Trap;
    endcase
  end

  // Next-state and control outputs; only the memory
  // handshakes and the branch flag are Mealy terms.
  always_comb begin
    nextState  = Fetch;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    reg_write  = 1'b0;
    alu_op     = 2'b00;
    instr_done = 1'b0;
    case (state)
      Fetch: begin
        alu_src_a  = SrcPc;
        alu_src_b  = SrcFour;
        alu_op     = AluAdd;
        result_src = ResAluRes;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        nextState  = mem_ready ? Decode : Fetch;
      end
      Decode: begin
        alu_src_a = SrcOldPc;
        alu_src_b = SrcImm;
        alu_op    = AluAdd;
        nextState = decodeNext;
      end
      MemAdr: begin
        alu_src_a = SrcRd1;
        alu_src_b = SrcImm;
        alu_op    = AluAdd;
        nextState = isLoad ? MemRead : MemWrite;
      end
      MemRead: begin
        adr_src   = 1'b1;
        nextState = mem_ready ? MemWb : MemRead;
      end
      MemWb: begin
        result_src = ResData;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nextState  = Fetch;
      end
      MemWrite: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        nextState  = mem_ready ? Fetch : MemWrite;
      end
      ExecR: begin
        alu_src_a = SrcRd1;
        alu_src_b = SrcRd2;
        alu_op    = AluFunct;
        nextState = AluWb;
      end
      ExecI: begin
        alu_src_a = SrcRd1;
        alu_src_b = SrcImm;
        alu_op    = AluFunct;
        nextState = AluWb;
      end
      AluWb: begin
        result_src = ResAluOut;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        nextState  = Fetch;
      end
      Beq: begin
        alu_src_a  = SrcRd1;
        alu_src_b  = SrcRd2;
        alu_op     = AluSub;
        result_src = ResAluOut;
        pc_write   = zero;
        instr_done = 1'b1;
        nextState  = Fetch;
      end
      Jal: begin
        alu_src_a  = SrcOldPc;
        alu_src_b  = SrcFour;
        alu_op     = AluAdd;
        result_src = ResAluOut;
        pc_write   = 1'b1;
        nextState  = AluWb;
      end
      Trap: begin
        nextState = Trap;
      end
      default: begin
        nextState = Fetch;
      end
    endcase
  end

  // Shared port must never write memory and the regfile together.
  always_comb begin
    if (reset_n) begin
      assert (!(mem_write && reg_write))
        else $error("mem_write and reg_write both high");
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: walks each instruction
// class cycle by cycle against hand-computed control values.
module tb_multicycle_ctrl;

  logic       clk;
  logic       reset_n;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic       reg_write;
  logic [1:0] alu_op;
  logic       instr_done;
  logic       illegal_instr;
  logic [3:0] dbg_state;

  int vectors;
  int miscompares;

  multicycle_ctrl #(.STATE_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .op           (op),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .pc_write     (pc_write),
    .adr_src      (adr_src),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .result_src   (result_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .imm_src      (imm_src),
    .reg_write    (reg_write),
    .alu_op       (alu_op),
    .instr_done   (instr_done),
    .illegal_instr(illegal_instr),
    .dbg_state    (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then apply inputs for the new cycle.
  task automatic cyc(input logic mr, input logic z);
    @(posedge clk);
    #1;
    mem_ready = mr;
    zero      = z;
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    op          = 7'b0000000;
    zero        = 1'b0;
    mem_ready   = 1'b0;

    #7;
    chk("rst_state", dbg_state, 0);
    chk("rst_irw", ir_write, 0);
    chk("rst_pcw", pc_write, 0);
    chk("rst_srcb", alu_src_b, 2);
    chk("rst_res", result_src, 2);
    chk("rst_ill", illegal_instr, 0);
    #1 reset_n = 1'b1;

    // Fetch stalls while memory is not ready
    cyc(0, 0);
    chk("stall_state", dbg_state, 0);
    chk("stall_irw", ir_write, 0);

    // lw: 0,1,2,3,4
    op = 7'b0000011;
    mem_ready = 1'b1;
    #1;
    chk("lw_f_irw", ir_write, 1);
    chk("lw_f_pcw", pc_write, 1);
    chk("lw_f_rw", reg_write, 0);
    cyc(1, 0);
    chk("lw_d_state", dbg_state, 1);
    chk("lw_d_a", alu_src_a, 1);
    chk("lw_d_b", alu_src_b, 1);
    chk("lw_d_imm", imm_src, 0);
    chk("lw_d_rw", reg_write, 0);
    cyc(1, 0);
    chk("lw_ma_state", dbg_state, 2);
    chk("lw_ma_a", alu_src_a, 2);
    chk("lw_ma_rw", reg_write, 0);
    cyc(1, 0);
    chk("lw_mr_state", dbg_state, 3);
    chk("lw_mr_adr", adr_src, 1);
    chk("lw_mr_mw", mem_write, 0);
    chk("lw_mr_done", instr_done, 0);
    cyc(1, 0);
    chk("lw_wb_state", dbg_state, 4);
    chk("lw_wb_rw", reg_write, 1);
    chk("lw_wb_res", result_src, 1);
    chk("lw_wb_done", instr_done, 1);
    cyc(1, 0);
    chk("lw_end_state", dbg_state, 0);
    chk("lw_end_rw", reg_write, 0);
    chk("lw_end_done", instr_done, 0);

    // sw with three not-ready cycles
    op = 7'b0100011;
    cyc(1, 0);
    chk("sw_d_imm", imm_src, 1);
    cyc(1, 0);
    chk("sw_ma_state", dbg_state, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0);
      chk("sw_wait_state", dbg_state, 5);
      chk("sw_wait_mw", mem_write, 1);
      chk("sw_wait_adr", adr_src, 1);
      chk("sw_wait_rw", reg_write, 0);
      chk("sw_wait_done", instr_done, 0);
    end
    cyc(1, 0);
    chk("sw_rdy_mw", mem_write, 1);
    chk("sw_rdy_done", instr_done, 1);
    cyc(1, 0);
    chk("sw_end_state", dbg_state, 0);
    chk("sw_end_mw", mem_write, 0);

    // R-type
    op = 7'b0110011;
    cyc(1, 0);
    cyc(1, 0);
    chk("r_ex_state", dbg_state, 6);
    chk("r_ex_a", alu_src_a, 2);
    chk("r_ex_b", alu_src_b, 0);
    chk("r_ex_op", alu_op, 2);
    cyc(1, 0);
    chk("r_wb_state", dbg_state, 8);
    chk("r_wb_rw", reg_write, 1);
    chk("r_wb_res", result_src, 0);
    chk("r_wb_done", instr_done, 1);
    cyc(1, 0);
    chk("r_end_state", dbg_state, 0);

    // I-type
    op = 7'b0010011;
    cyc(1, 0);
    cyc(1, 0);
    chk("i_ex_state", dbg_state, 7);
    chk("i_ex_b", alu_src_b, 1);
    chk("i_ex_op", alu_op, 2);
    cyc(1, 0);
    chk("i_wb_state", dbg_state, 8);
    cyc(1, 0);
    chk("i_end_state", dbg_state, 0);

    // beq taken
    op = 7'b1100011;
    cyc(1, 0);
    chk("bt_d_imm", imm_src, 2);
    cyc(1, 1);
    chk("bt_state", dbg_state, 9);
    chk("bt_pcw", pc_write, 1);
    chk("bt_op", alu_op, 1);
    chk("bt_done", instr_done, 1);
    cyc(1, 0);
    chk("bt_end_state", dbg_state, 0);

    // beq not taken
    cyc(1, 0);
    cyc(1, 0);
    chk("bn_state", dbg_state, 9);
    chk("bn_pcw", pc_write, 0);
    chk("bn_done", instr_done, 1);
    cyc(1, 0);
    chk("bn_end_state", dbg_state, 0);

    // jal
    op = 7'b1101111;
    cyc(1, 0);
    chk("j_d_imm", imm_src, 3);
    cyc(1, 0);
    chk("j_state", dbg_state, 10);
    chk("j_pcw", pc_write, 1);
    chk("j_res", result_src, 0);
    chk("j_a", alu_src_a, 1);
    chk("j_b", alu_src_b, 2);
    chk("j_rw", reg_write, 0);
    cyc(1, 0);
    chk("j_wb_state", dbg_state, 8);
    chk("j_wb_rw", reg_write, 1);
    chk("j_wb_pcw", pc_write, 0);
    cyc(1, 0);
    chk("j_end_state", dbg_state, 0);

    // reset in the middle of ExecR
    op = 7'b0110011;
    cyc(1, 0);
    cyc(1, 0);
    chk("rr_state", dbg_state, 6);
    reset_n   = 1'b0;
    mem_ready = 1'b0;
    #1;
    chk("rr_rst_state", dbg_state, 0);
    chk("rr_rst_irw", ir_write, 0);
    chk("rr_rst_pcw", pc_write, 0);
    #1 reset_n = 1'b1;
    cyc(1, 0);
    chk("rr_after_state", dbg_state, 0);

    // reset during a pending write
    op = 7'b0100011;
    cyc(1, 0);
    cyc(0, 0);
    cyc(0, 0);
    chk("rw_state", dbg_state, 5);
    chk("rw_mw", mem_write, 1);
    reset_n = 1'b0;
    #1;
    chk("rw_rst_mw", mem_write, 0);
    chk("rw_rst_state", dbg_state, 0);
    #1 reset_n = 1'b1;

    // unsupported opcode traps
    op = 7'b1110011;
    cyc(1, 0);
    chk("t_pre_state", dbg_state, 0);
    cyc(1, 0);
    chk("t_d_state", dbg_state, 1);
    chk("t_d_ill", illegal_instr, 0);
    cyc(1, 1);
    chk("t_state", dbg_state, 11);
    chk("t_ill", illegal_instr, 1);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 1);
      chk("t_hold_state", dbg_state, 11);
      chk("t_hold_ill", illegal_instr, 1);
      chk("t_hold_strb",
          {pc_write, mem_write, ir_write, reg_write, instr_done}, 0);
    end
    reset_n = 1'b0;
    #1;
    chk("t_rst_ill", illegal_instr, 0);
    chk("t_rst_state", dbg_state, 0);
    #1 reset_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
